mc_ctrl_fsm: RTL and testbench

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

---
 rtl/mc_pkg.sv | 33 +++
 rtl/mc_ctrl_fsm_if.sv | 33 +++
 rtl/mc_ctrl_decode.sv | 25 ++
 rtl/mc_ctrl_fsm.sv | 106 ++++++++++
 tb/tb_mc_ctrl_fsm.sv | 136 +++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multi-cycle controller.
package mc_pkg;
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        MULW   = 3'd5,
        HALT   = 3'd6
    } state_e;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_MULI = 6'b000010;
    localparam logic [5:0] OP_SUBI = 6'b000011;
    localparam logic [5:0] OP_LW   = 6'b000100;
    localparam logic [5:0] OP_SW   = 6'b000101;
    localparam logic [5:0] OP_BEQ  = 6'b000110;
    localparam logic [5:0] OP_J    = 6'b000111;
    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [2:0] C_FUNC = 3'd0;
    localparam logic [2:0] C_ADD  = 3'd1;
    localparam logic [2:0] C_MUL  = 3'd2;
    localparam logic [2:0] C_SUB  = 3'd3;
    localparam logic [1:0] PC_ALU = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JMP = 2'd2;
    localparam logic [1:0] SRCB_B    = 2'd0;
    localparam logic [1:0] SRCB_4    = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;
    localparam logic [1:0] SRCB_IMM2 = 2'd3;
    localparam logic [5:0] MUL_FUNC_DEF = 6'b000011;
endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: instruction/status inputs and datapath control outputs.
interface mc_ctrl_fsm_if;
    logic [5:0] opcode;
    logic [5:0] i_func;
    logic       zero;
    logic       mem_ready;
    logic       mul_done;
    logic [2:0] c_sig;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       mul_start;
    logic       halted;
    logic [2:0] state;
    modport master (
        output opcode, i_func, zero, mem_ready, mul_done,
        input  c_sig, pc_en, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, mul_start, halted, state
    );
    modport slave (
        input  opcode, i_func, zero, mem_ready, mul_done,
        output c_sig, pc_en, pc_src, ir_write, iord, mem_read, mem_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, mul_start, halted, state
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: classifies the opcode/function pair into instruction groups.
module mc_ctrl_decode import mc_pkg::*; #(
    parameter logic [5:0] MUL_FUNC = MUL_FUNC_DEF
) (
    input  logic [5:0] opcode_i,
    input  logic [5:0] func_i,
    output logic       is_r_o,
    output logic       is_imm_o,
    output logic       is_mem_o,
    output logic       is_mul_o,
    output logic       is_branch_o,
    output logic       is_jump_o,
    output logic       is_halt_o,
    output logic       is_illegal_o
);
    assign is_r_o       = opcode_i == OP_R;
    assign is_imm_o     = opcode_i == OP_ADDI || opcode_i == OP_SUBI;
    assign is_mem_o     = opcode_i == OP_LW || opcode_i == OP_SW;
    assign is_mul_o     = opcode_i == OP_MULI || (is_r_o && func_i == MUL_FUNC);
    assign is_branch_o  = opcode_i == OP_BEQ;
    assign is_jump_o    = opcode_i == OP_J;
    assign is_halt_o    = opcode_i == OP_HALT;
    assign is_illegal_o = !(is_r_o || is_imm_o || is_mem_o || is_mul_o ||
                            is_branch_o || is_jump_o || is_halt_o);
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle CPU control FSM with memory and multiplier wait states.
module mc_ctrl_fsm import mc_pkg::*; #(
    parameter logic [5:0] MUL_FUNC = MUL_FUNC_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    mc_ctrl_fsm_if.slave  bus
);
    state_e state_q, state_d;
    logic   started_q;
    logic   is_r, is_imm, is_mem, is_mul, is_branch, is_jump, is_halt, is_illegal;
    mc_ctrl_decode #(.MUL_FUNC(MUL_FUNC)) u_decode (
        .opcode_i     (bus.opcode),
        .func_i       (bus.i_func),
        .is_r_o       (is_r),
        .is_imm_o     (is_imm),
        .is_mem_o     (is_mem),
        .is_mul_o     (is_mul),
        .is_branch_o  (is_branch),
        .is_jump_o    (is_jump),
        .is_halt_o    (is_halt),
        .is_illegal_o (is_illegal)
    );
    // started_q marks every MULW cycle after the first, so mul_start is a single pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            started_q <= state_q == MULW;
        end
    end
    assign bus.state = state_q;
    always_comb begin
        state_d        = state_q;
        bus.c_sig      = C_ADD;
        bus.pc_en      = 1'b0;
        bus.pc_src     = PC_ALU;
        bus.ir_write   = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_B;
        bus.mul_start  = 1'b0;
        bus.halted     = 1'b0;
        case (state_q)
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRCB_4;
                bus.ir_write  = bus.mem_ready;
                bus.pc_en     = bus.mem_ready;
                state_d       = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                bus.alu_src_b = SRCB_IMM2;
                bus.pc_en     = is_jump;
                bus.pc_src    = is_jump ? PC_JMP : PC_ALU;
                state_d       = (is_jump || is_illegal) ? FETCH :
                                is_halt ? HALT : is_mul ? MULW : EXEC;
            end
            EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = (is_imm || is_mem) ? SRCB_IMM : SRCB_B;
                bus.c_sig     = is_r ? C_FUNC :
                                (is_branch || bus.opcode == OP_SUBI) ? C_SUB : C_ADD;
                bus.pc_src    = is_branch ? PC_BR : PC_ALU;
                bus.pc_en     = is_branch && bus.zero;
                state_d       = (is_r || is_imm) ? WB : is_mem ? MEM : FETCH;
            end
            MULW: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = bus.opcode == OP_MULI ? SRCB_IMM : SRCB_B;
                bus.c_sig     = bus.opcode == OP_MULI ? C_MUL : C_FUNC;
                bus.mul_start = !started_q;
                state_d       = bus.mul_done ? WB : MULW;
            end
            MEM: begin
                bus.iord      = 1'b1;
                bus.mem_read  = bus.opcode == OP_LW;
                bus.mem_write = bus.opcode == OP_SW;
                state_d       = !bus.mem_ready ? MEM : bus.opcode == OP_LW ? WB : FETCH;
            end
            WB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = is_r;
                bus.mem_to_reg = bus.opcode == OP_LW;
                state_d        = FETCH;
            end
            HALT: bus.halted = 1'b1;
            default: state_d = FETCH;
        endcase
        // reset suppresses every side-effecting strobe in the cycle it is sampled
        if (!rst_n) begin
            bus.pc_en     = 1'b0;
            bus.ir_write  = 1'b0;
            bus.reg_write = 1'b0;
            bus.mem_write = 1'b0;
            bus.mul_start = 1'b0;
        end
    end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed per-cycle scoreboard check of state and all control outputs.
module tb_mc_ctrl_fsm;
    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [17:0] ctl;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_n;
    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [17:0] ctl_o, f_rdy, f_stl, dec, ex_imm, wb_i, wb_r, wb_lw, mem_lw, mem_sw, hlt;
    always #5 clk = ~clk;
    mc_ctrl_fsm_if bus();
    mc_ctrl_fsm #(.MUL_FUNC(6'b000011)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    assign ctl_o = {bus.halted, bus.mul_start, bus.alu_src_b, bus.alu_src_a, bus.mem_to_reg,
                    bus.reg_dst, bus.reg_write, bus.mem_write, bus.mem_read, bus.iord,
                    bus.ir_write, bus.pc_en, bus.pc_src, bus.c_sig};
    function automatic logic [17:0] v(input logic [2:0] c, input logic [1:0] ps,
        input logic pe, irw, io, mr, mw, rw, rd, m2r, sa, input logic [1:0] sb, input logic ms, h);
        return {h, ms, sb, sa, m2r, rd, rw, mw, mr, io, irw, pe, ps, c};
    endfunction
    task automatic cyc(input string tag, input logic [2:0] st, input logic [17:0] ctl);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.ctl = ctl;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        n_vec++;
        assert (bus.state === e.st) else begin
            n_bad++;
            $error("FAIL %s state: got %0d want %0d", e.tag, bus.state, e.st);
        end
        n_vec++;
        assert (ctl_o === e.ctl) else begin
            n_bad++;
            $error("FAIL %s ctl: got %h want %h", e.tag, ctl_o, e.ctl);
        end
        @(posedge clk);
        #1;
    endtask
    task automatic fd(input string tag, input logic [5:0] op, input logic [5:0] fn);
        bus.opcode = op;
        bus.i_func = fn;
        cyc({tag, "_f"}, 3'd0, f_rdy);
        cyc({tag, "_d"}, 3'd1, dec);
    endtask
    initial begin
        f_rdy  = v(1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        f_stl  = v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        dec    = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        ex_imm = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
        wb_i   = v(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        wb_r   = v(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        wb_lw  = v(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        mem_lw = v(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        mem_sw = v(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        hlt    = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        bus.opcode = '0;
        bus.i_func = '0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mul_done = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc("rst", 3'd0, f_stl);
        rst_n = 1'b1;
        fd("addi", 6'd1, 6'd0);
        cyc("addi_ex", 3'd2, ex_imm);
        cyc("addi_wb", 3'd4, wb_i);
        fd("subi", 6'd3, 6'd0);
        cyc("subi_ex", 3'd2, v(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        cyc("subi_wb", 3'd4, wb_i);
        fd("radd", 6'd0, 6'h20);
        cyc("radd_ex", 3'd2, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        cyc("radd_wb", 3'd4, wb_r);
        fd("lw", 6'd4, 6'd0);
        cyc("lw_ex", 3'd2, ex_imm);
        bus.mem_ready = 1'b0;
        repeat (3) cyc("lw_mem_wait", 3'd3, mem_lw);
        bus.mem_ready = 1'b1;
        cyc("lw_mem_done", 3'd3, mem_lw);
        cyc("lw_wb", 3'd4, wb_lw);
        fd("sw", 6'd5, 6'd0);
        cyc("sw_ex", 3'd2, ex_imm);
        cyc("sw_mem", 3'd3, mem_sw);
        bus.zero = 1'b1;
        fd("beq1", 6'd6, 6'd0);
        cyc("beq1_ex", 3'd2, v(3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        bus.zero = 1'b0;
        fd("beq0", 6'd6, 6'd0);
        cyc("beq0_ex", 3'd2, v(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        bus.opcode = 6'd7;
        cyc("j_f", 3'd0, f_rdy);
        cyc("j_d", 3'd1, v(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
        bus.opcode = 6'd0;
        bus.i_func = 6'b000011;
        bus.mul_done = 1'b1;
        cyc("rmul_f", 3'd0, f_rdy);
        bus.mul_done = 1'b0;
        cyc("rmul_d", 3'd1, dec);
        cyc("rmul_w1", 3'd5, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        repeat (3) cyc("rmul_w", 3'd5, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        bus.mul_done = 1'b1;
        cyc("rmul_w5", 3'd5, v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        bus.mul_done = 1'b0;
        cyc("rmul_wb", 3'd4, wb_r);
        fd("muli", 6'd2, 6'd0);
        bus.mul_done = 1'b1;
        cyc("muli_w", 3'd5, v(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0));
        bus.mul_done = 1'b0;
        cyc("muli_wb", 3'd4, wb_i);
        fd("nop", 6'b101010, 6'd0);
        fd("swr", 6'd5, 6'd0);
        cyc("swr_ex", 3'd2, ex_imm);
        bus.mem_ready = 1'b0;
        rst_n = 1'b0;
        cyc("swr_mem_rst", 3'd3, v(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        cyc("swr_fetch", 3'd0, f_stl);
        bus.mem_ready = 1'b1;
        fd("halt", 6'h3f, 6'd0);
        bus.opcode = 6'd1;
        repeat (3) cyc("halt_hold", 3'd6, hlt);
        rst_n = 1'b0;
        cyc("halt_rst", 3'd6, hlt);
        rst_n = 1'b1;
        cyc("post_rst", 3'd0, f_rdy);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
